multicycle_control_unit: RTL and testbench

Sequencing controller for the multi-cycle RV32I datapath, replacing the single-cycle decoder in that datapath. A state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives per-state strobes and mux selects, waits on a shared instruction/data memory through a ready handshake, and traps illegal opcodes and memory timeouts into a sticky error state. It supports R-type ADD/SUB/AND/OR, loads, stores, BEQ/BNE and, optionally, OP-IMM ADDI/ANDI/ORI.

---
 rtl/multicycle_control_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencing controller.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, waits on a shared memory through mem_ready and traps illegal
// opcodes or memory timeouts into a sticky ERROR state.

package definitions_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
endpackage

module multicycle_control_unit
    import definitions_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter bit EN_OP_IMM   = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            result_src,
    output logic                  illegal,
    output logic [1:0]            err_code,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_ERROR   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // A zero timeout still needs a one-bit counter to keep the width legal.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         err_q, err_d;
    logic               illegal_q;
    logic               waiting;
    logic               timed_out;
    logic [2:0]         alu_op;

    assign state    = state_q;
    assign illegal  = illegal_q;
    assign err_code = err_q;

    // Cycles that count toward the timeout are the memory-wait states.
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready arriving on the limit cycle wins, hence the !mem_ready term.
    assign timed_out = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

    // State, timeout counter and sticky error flags.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            err_q     <= ERR_NONE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            illegal_q <= (state_d == S_ERROR);
            if (state_d != state_q)
                cnt_q <= '0;
            else if (waiting && !mem_ready)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next-state selection and per-state strobes/selects.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        err_d      = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        result_src = 2'd0;

        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                // ALUOut captures old PC + immediate: the branch target.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_IMM: begin
                        if (EN_OP_IMM) begin
                            state_d = S_EXEC_I;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = ERR_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                state_d   = S_ALU_WB;
                case (funct3)
                    3'b000:  alu_op = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                state_d   = S_ALU_WB;
                case (funct3)
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                alu_op    = ALU_SUB;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                state_d   = S_FETCH;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset forces every strobe and select low regardless of state.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 3'd0;
            result_src = 2'd0;
        end

        alu_control = ALU_CTRL_W'(alu_op);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_TIMEOUT = 4).
// Expected per-cycle output vectors and mem_ready values are queued per
// instruction, then popped and compared cycle by cycle.

module tb_multicycle_control_unit;

    localparam logic [2:0] A_ADD = 3'd0;
    localparam logic [2:0] A_SUB = 3'd1;
    localparam logic [2:0] A_AND = 3'd2;
    localparam logic [2:0] A_OR  = 3'd3;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] res;
        logic       ill;
        logic [1:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, err_code;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];
    logic rdy_q[$];
    exp_t obs;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .ALU_CTRL_W  (3),
        .EN_OP_IMM   (1'b1),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .result_src  (result_src),
        .illegal     (illegal),
        .err_code    (err_code),
        .state       (state)
    );

    always_comb begin
        obs.st       = state;
        obs.mem_req  = mem_req;
        obs.mem_we   = mem_we;
        obs.adr_src  = adr_src;
        obs.ir_write = ir_write;
        obs.pc_write = pc_write;
        obs.reg_write = reg_write;
        obs.src_a    = alu_src_a;
        obs.src_b    = alu_src_b;
        obs.alu      = alu_control;
        obs.res      = result_src;
        obs.ill      = illegal;
        obs.err      = err_code;
    end

    // Expected output vectors, one per controller state.
    function automatic exp_t blank(input logic [3:0] s);
        exp_t e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t x_fetch(input logic r);
        exp_t e = blank(4'd0);
        e.mem_req = 1'b1; e.ir_write = r; e.pc_write = r;
        e.src_b = 2'd1; e.alu = A_ADD; e.res = 2'd2;
        return e;
    endfunction

    function automatic exp_t x_decode();
        exp_t e = blank(4'd1);
        e.src_a = 2'd1; e.src_b = 2'd2; e.alu = A_ADD;
        return e;
    endfunction

    function automatic exp_t x_memadr();
        exp_t e = blank(4'd2);
        e.src_a = 2'd2; e.src_b = 2'd2; e.alu = A_ADD;
        return e;
    endfunction

    function automatic exp_t x_memrd();
        exp_t e = blank(4'd3);
        e.mem_req = 1'b1; e.adr_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t x_memwb();
        exp_t e = blank(4'd4);
        e.res = 2'd1; e.reg_write = 1'b1;
        return e;
    endfunction

    function automatic exp_t x_memwr();
        exp_t e = blank(4'd5);
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t x_execr(input logic [2:0] op);
        exp_t e = blank(4'd6);
        e.src_a = 2'd2; e.src_b = 2'd0; e.alu = op;
        return e;
    endfunction

    function automatic exp_t x_execi(input logic [2:0] op);
        exp_t e = blank(4'd7);
        e.src_a = 2'd2; e.src_b = 2'd2; e.alu = op;
        return e;
    endfunction

    function automatic exp_t x_aluwb();
        exp_t e = blank(4'd8);
        e.reg_write = 1'b1; e.res = 2'd0;
        return e;
    endfunction

    function automatic exp_t x_branch(input logic pc);
        exp_t e = blank(4'd9);
        e.src_a = 2'd2; e.src_b = 2'd0; e.alu = A_SUB; e.pc_write = pc;
        return e;
    endfunction

    function automatic exp_t x_error(input logic [1:0] code);
        exp_t e = blank(4'd10);
        e.ill = 1'b1; e.err = code;
        return e;
    endfunction

    task automatic push(input exp_t e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    task automatic compare(input string tag, input int n, input exp_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%h expected=%h", tag, n, obs, e);
        end
    endtask

    // Play queued mem_ready values one per cycle and compare each cycle's outputs.
    task automatic drain(input string tag);
        int n;
        exp_t e;
        n = 0;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compare(tag, n, e);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z);
        opcode = opc;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
    endtask

    task automatic rtype(input string tag, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [2:0] op);
        set_instr(7'b0110011, f3, f7, 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_execr(op), 1'b1);
        push(x_aluwb(), 1'b1);
        drain(tag);
    endtask

    task automatic itype(input string tag, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [2:0] op);
        set_instr(7'b0010011, f3, f7, 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_execi(op), 1'b1);
        push(x_aluwb(), 1'b1);
        drain(tag);
    endtask

    task automatic branch(input string tag, input logic [2:0] f3,
                          input logic z, input logic taken);
        set_instr(7'b1100011, f3, 7'd0, z);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_branch(taken), 1'b1);
        drain(tag);
    endtask

    // Holds rst across one rising edge and checks the cleared state while rst is still high.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        compare(tag, 0, blank(4'd0));
        rst = 1'b0;
    endtask

    initial begin
        set_instr(7'd0, 3'd0, 7'd0, 1'b0);
        do_reset("reset");

        rtype("r_add",   3'b000, 7'b0000000, A_ADD);
        rtype("r_sub",   3'b000, 7'b0100000, A_SUB);
        rtype("r_and",   3'b111, 7'b0000000, A_AND);
        rtype("r_or",    3'b110, 7'b0000000, A_OR);
        rtype("r_f7add", 3'b000, 7'b0000001, A_ADD);
        rtype("r_f3dft", 3'b100, 7'b0100000, A_ADD);

        itype("i_addi",  3'b000, 7'b0100000, A_ADD);
        itype("i_andi",  3'b111, 7'b0100000, A_AND);
        itype("i_ori",   3'b110, 7'b0000000, A_OR);

        // Load: one fetch wait, then three MEM_RD waits.
        set_instr(7'b0000011, 3'b010, 7'd0, 1'b0);
        push(x_fetch(1'b0), 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b0);
        push(x_memadr(), 1'b0);
        push(x_memrd(), 1'b0);
        push(x_memrd(), 1'b0);
        push(x_memrd(), 1'b0);
        push(x_memrd(), 1'b1);
        push(x_memwb(), 1'b0);
        drain("load_wait");

        // Zero-wait store.
        set_instr(7'b0100011, 3'b010, 7'd0, 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_memadr(), 1'b1);
        push(x_memwr(), 1'b1);
        drain("store");

        branch("beq_z1",   3'b000, 1'b1, 1'b1);
        branch("beq_z0",   3'b000, 1'b0, 1'b0);
        branch("bne_z1",   3'b001, 1'b1, 1'b0);
        branch("bne_z0",   3'b001, 1'b0, 1'b1);
        branch("b100_z1",  3'b100, 1'b1, 1'b0);
        branch("b100_z0",  3'b100, 1'b0, 1'b0);

        // Store where mem_ready arrives exactly on the limit cycle.
        set_instr(7'b0100011, 3'b010, 7'd0, 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_memadr(), 1'b1);
        for (int i = 0; i < 4; i++) push(x_memwr(), 1'b0);
        push(x_memwr(), 1'b1);
        push(x_fetch(1'b0), 1'b0);
        drain("store_limit_ready");

        // Store timeout: five wait cycles in MEM_WR, then ERROR with code 2.
        set_instr(7'b0100011, 3'b010, 7'd0, 1'b0);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        push(x_memadr(), 1'b1);
        for (int i = 0; i < 5; i++) push(x_memwr(), 1'b0);
        for (int i = 0; i < 4; i++) push(x_error(2'd2), 1'($urandom_range(0, 1)));
        drain("store_timeout");
        do_reset("reset_after_timeout");

        // Illegal opcode: ERROR with code 1, held for 20 cycles whatever mem_ready does.
        set_instr(7'b1111111, 3'b000, 7'd0, 1'b1);
        push(x_fetch(1'b1), 1'b1);
        push(x_decode(), 1'b1);
        for (int i = 0; i < 20; i++) push(x_error(2'd1), 1'($urandom_range(0, 1)));
        drain("illegal_op");
        do_reset("reset_after_illegal");

        // Normal operation resumes after leaving ERROR.
        rtype("r_after_reset", 3'b000, 7'b0100000, A_SUB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
